qsfp_i2c_target: RTL and testbench
==================================

// Module: qsfp_i2c_target
// PURPOSE
//  I2C target (responder) for the QSFP management I2C bus; the far end of the QSFP I2C controller.
//  Decodes START/STOP, matches a 7-bit device address and ACKs.
//  Accepts an 8-bit register pointer, then services write and read bursts against a 256x8 memory port.
//  Used as the QSFP module EEPROM model on the board/sim side of the QSFP subsystem.
// PARAMETERS
//  DEV_ADDR  7'h50  7-bit target address (QSFP A0h page)
//  HOLD_CYC  4      clk cycles after SCL fall before sda_oe may change (SDA hold time), >=1
// PORTS
//  clk        in   1  system clock, >= 8x SCL rate
//  rst_n      in   1  asynchronous active-low reset
//  scl_i      in   1  SCL line level (asynchronous)
//  sda_i      in   1  SDA line level (asynchronous)
//  sda_oe     out  1  1 = pull SDA low (open-drain), 0 = release
//  mem_addr   out  8  memory address (register pointer)
//  mem_wr     out  1  one-cycle write strobe
//  mem_wdata  out  8  write data, valid with mem_wr
//  mem_rdata  in   8  read data, valid 1 clk after mem_addr changes
//  busy       out  1  1 from START to STOP
// BEHAVIOUR
//  Reset: sda_oe=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0, state=IDLE, pointer=0.
//  Reset asserted mid-transfer releases SDA the same cycle (asynchronous).
//  Input sync: scl_i/sda_i pass 2-FF synchronizers plus a delay stage; edges are seen 3 clks after the pin.
//  START = SDA fall while SCL high. STOP = SDA rise while SCL high.
//  START/STOP are valid in any state and override all other activity.
//  START (including a repeated START) -> ADDR, bit count=0, busy=1. STOP -> IDLE, busy=0, sda_oe=0.
//  Data bits are sampled on SCL rise. sda_oe changes only HOLD_CYC clks after an SCL fall.
//  States:
//   IDLE     waiting for START.
//   ADDR     shift 8 bits MSB first. [7:1]==DEV_ADDR -> ADDR_ACK; otherwise -> IGNORE (no ACK).
//   ADDR_ACK drive ACK for one SCL period. R/W=0 -> REG. R/W=1 -> load shift reg from mem_rdata -> RDATA.
//   REG      shift pointer byte -> REG_ACK (ACK) -> WDATA; pointer=byte; mem_addr=pointer.
//   WDATA    shift byte -> WR_ACK. On the 8th SCL rise: mem_wr=1 for 1 clk with mem_addr=pointer.
//            Pointer then +1. ACK is driven; -> WDATA.
//   RDATA    drive each bit (sda_oe=~bit) at SCL fall+HOLD_CYC, 8 bits -> RD_ACK; release SDA.
//   RD_ACK   sample controller ACK at SCL rise; pointer +1.
//            ACK(0) -> fetch mem[pointer], reload at next SCL fall -> RDATA. NACK(1) -> IGNORE.
//   IGNORE   sda_oe=0 until START or STOP.
//  Pointer is 8 bits and wraps 0xFF -> 0x00 on both read and write bursts.
//  Pointer persists across STOP and repeated START.
//  mem_addr always equals pointer; mem_rdata is sampled >=2 clks after a pointer change.
//  Read fetch: first byte of a read uses the current pointer (random read = write ptr, Sr, read).
//  STOP or START mid-byte: the partial byte is discarded; no mem_wr.
//  SCL stretching is never used.
//  Address byte 0x00 (general call) is not matched.
//  Glitches shorter than 2 clks on SCL/SDA are not filtered; the bench must not apply them.
// TESTING
//  Write S,0xA0,0x7F,0xA5,P -> three ACKs; one mem_wr pulse with addr=0x7F, wdata=0xA5; busy 0 after P.
//  Random read S,0xA0,0x10,Sr,0xA1,rd(ACK),rd(NACK),P with mem[0x10]=0x3C, mem[0x11]=0xC3
//   -> bytes 0x3C then 0xC3 on SDA; pointer=0x12 after.
//  Write burst pointer 0xFE, data 0x01,0x02,0x03 -> mem_wr at addr 0xFE, 0xFF, 0x00; no extra strobe.
//  Address mismatch S,0xA2 -> SDA released in ACK slot (NACK); no mem_wr.
//   A following S,0xA0 is ACKed normally.
//  STOP after 4 data bits of WDATA -> no mem_wr; state IDLE; busy=0.
//  rst_n low while driving a 0 bit in RDATA -> sda_oe=0 the same cycle.
//   After rst_n rises, the next S,0xA1 reads mem[0x00].

Source files
------------

// File: rtl/qsfp_i2c_target.sv
// rtl/qsfp_i2c_target.sv - QSFP management I2C target (EEPROM model) driving a 256x8 memory port
module qsfp_i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         HOLD_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] mem_addr,
    output logic       mem_wr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       busy
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
        ST_WDATA, ST_WR_ACK, ST_RDATA, ST_RD_ACK, ST_IGNORE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      scl_sync_q, sda_sync_q;
    logic [2:0]      cnt_q, cnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      ptr_q, ptr_d;
    logic            wr_q, wr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            oe_q, oe_d;
    logic            pend_q, pend_d;
    logic            pval_q, pval_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            sched, sched_val;

    // [1] is the synchronized level, [2] the one-clock-older copy used for edge detection
    logic scl_now, scl_prev, sda_now, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;
    logic addr_match;

    assign scl_now    = scl_sync_q[1];
    assign scl_prev   = scl_sync_q[2];
    assign sda_now    = sda_sync_q[1];
    assign sda_prev   = sda_sync_q[2];
    assign scl_rise   = scl_now & ~scl_prev;
    assign scl_fall   = ~scl_now & scl_prev;
    assign start_det  = scl_now & scl_prev & sda_prev & ~sda_now;
    assign stop_det   = scl_now & scl_prev & ~sda_prev & sda_now;
    assign byte_in    = {shift_q[6:0], sda_now};
    assign addr_match = (byte_in[7:1] == DEV_ADDR) && (byte_in[7:1] != 7'h00);

    assign sda_oe    = oe_q;
    assign mem_addr  = ptr_q;
    assign mem_wr    = wr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            phase_q    <= 2'd0;
            shift_q    <= 8'h00;
            ptr_q      <= 8'h00;
            wr_q       <= 1'b0;
            wdata_q    <= 8'h00;
            oe_q       <= 1'b0;
            pend_q     <= 1'b0;
            pval_q     <= 1'b0;
            hold_q     <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl_i};
            sda_sync_q <= {sda_sync_q[1:0], sda_i};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            oe_q       <= oe_d;
            pend_q     <= pend_d;
            pval_q     <= pval_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        wr_d      = 1'b0;
        wdata_d   = wdata_q;
        oe_d      = oe_q;
        pend_d    = pend_q;
        pval_d    = pval_q;
        hold_d    = hold_q;
        sched     = 1'b0;
        sched_val = 1'b0;

        // Pointer advances the clock after the strobe so mem_addr is stable while mem_wr is high
        if (wr_q) ptr_d = ptr_q + 8'd1;

        if (pend_q) begin
            if (hold_q == HW'(1)) begin
                oe_d   = pval_q;
                pend_d = 1'b0;
            end else begin
                hold_d = hold_q - HW'(1);
            end
        end

        if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
            pend_d  = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: if (scl_rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        phase_d = 2'd0;
                        state_d = addr_match ? ST_ADDR_ACK : ST_IGNORE;
                    end
                end
                // ACK slots: phase 0 waits for the fall that opens the slot, phase 1 for the one closing it
                ST_ADDR_ACK: if (scl_fall) begin
                    sched = 1'b1;
                    if (phase_q == 2'd0) begin
                        sched_val = 1'b1;
                        phase_d   = 2'd1;
                    end else begin
                        cnt_d = 3'd0;
                        if (shift_q[0]) begin
                            shift_d   = mem_rdata;
                            sched_val = ~mem_rdata[7];
                            state_d   = ST_RDATA;
                        end else begin
                            state_d   = ST_REG;
                        end
                    end
                end
                ST_REG: if (scl_rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        ptr_d   = byte_in;
                        phase_d = 2'd0;
                        state_d = ST_REG_ACK;
                    end
                end
                ST_REG_ACK, ST_WR_ACK: if (scl_fall) begin
                    sched = 1'b1;
                    if (phase_q == 2'd0) begin
                        sched_val = 1'b1;
                        phase_d   = 2'd1;
                    end else begin
                        cnt_d   = 3'd0;
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA: if (scl_rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        wr_d    = 1'b1;
                        wdata_d = byte_in;
                        phase_d = 2'd0;
                        state_d = ST_WR_ACK;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            phase_d = 2'd0;
                            state_d = ST_RD_ACK;
                        end
                    end else if (scl_fall) begin
                        sched     = 1'b1;
                        sched_val = ~shift_q[7];
                    end
                end
                // Phase 0: release SDA; 1: sample controller ACK; 2: reload the next byte
                ST_RD_ACK: begin
                    if (scl_fall && phase_q == 2'd0) begin
                        sched   = 1'b1;
                        phase_d = 2'd1;
                    end else if (scl_rise && phase_q == 2'd1) begin
                        ptr_d = ptr_q + 8'd1;
                        if (!sda_now) phase_d = 2'd2;
                        else          state_d = ST_IGNORE;
                    end else if (scl_fall && phase_q == 2'd2) begin
                        shift_d   = mem_rdata;
                        sched     = 1'b1;
                        sched_val = ~mem_rdata[7];
                        cnt_d     = 3'd0;
                        state_d   = ST_RDATA;
                    end
                end
                ST_IGNORE: oe_d = 1'b0;
                default:   state_d = ST_IDLE;
            endcase
        end

        if (sched) begin
            pend_d = 1'b1;
            pval_d = sched_val;
            hold_d = HW'(HOLD_CYC);
        end
    end

endmodule

// File: tb/tb_qsfp_i2c_target.sv
// tb/tb_qsfp_i2c_target.sv - bit-banged I2C controller bench with write/read scoreboards
module tb_qsfp_i2c_target;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] mem_addr;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  exp_rd_q[$];
    logic [15:0] exp_wr_q[$];
    logic [15:0] obs_wr[64];
    int          obs_n = 0;
    int          obs_idx = 0;

    logic       tb_we = 1'b0;
    logic [7:0] tb_wa = 8'h00;
    logic [7:0] tb_wd = 8'h00;
    logic [7:0] mem[256];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    qsfp_i2c_target #(.DEV_ADDR(7'h50), .HOLD_CYC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (tb_we)       mem[tb_wa] <= tb_wd;
        else if (mem_wr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_wr) begin
            if (obs_n < 64) obs_wr[obs_n] = {mem_addr, mem_wdata};
            obs_n = obs_n + 1;
        end
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        tb_wa = a;
        tb_wd = d;
        tb_we = 1'b1;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic i2c_start();
        wait_q();
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        wait_q();
        sda_m = b;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        r = sda_line;
        wait_q();
        scl_m = 1'b0;
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
        i2c_bit(1'b1, ack);
    endtask

    task automatic rbyte(input logic ackbit, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            d[i] = r;
        end
        i2c_bit(ackbit, r);
    endtask

    task automatic test_reset();
        n_checks += 5;
        if (sda_oe !== 1'b0)     begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        if (mem_wr !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        if (mem_addr !== 8'h00)  begin n_fail++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write();
        logic ack;
        logic [15:0] e;
        i2c_start();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_start: got %b want 1", busy); end
        wbyte(8'hA0, ack);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL write_addr_ack: got %b want 0", ack); end
        wbyte(8'h7F, ack);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL write_reg_ack: got %b want 0", ack); end
        exp_wr_q.push_back({8'h7F, 8'hA5});
        wbyte(8'hA5, ack);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL write_data_ack: got %b want 0", ack); end
        i2c_stop();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_stop: got %b want 0", busy); end
        while (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            n_checks++;
            if (obs_idx >= obs_n) begin
                n_fail++; $display("FAIL write_strobe: missing, want addr/data %h", e);
            end else begin
                if (obs_wr[obs_idx] !== e) begin n_fail++; $display("FAIL write_strobe: got %h want %h", obs_wr[obs_idx], e); end
                obs_idx++;
            end
        end
        n_checks++;
        if (obs_n !== obs_idx) begin n_fail++; $display("FAIL write_strobe_count: got %0d want %0d", obs_n, obs_idx); end
        obs_idx = obs_n;
        n_checks++;
        if (mem_addr !== 8'h80) begin n_fail++; $display("FAIL write_pointer: got %h want 80", mem_addr); end
    endtask

    task automatic test_random_read();
        logic ack;
        logic [7:0] d, e;
        preload(8'h10, 8'h3C);
        preload(8'h11, 8'hC3);
        i2c_start();
        wbyte(8'hA0, ack);
        wbyte(8'h10, ack);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL read_ptr_ack: got %b want 0", ack); end
        i2c_start();
        wbyte(8'hA1, ack);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL read_addr_ack: got %b want 0", ack); end
        exp_rd_q.push_back(8'h3C);
        exp_rd_q.push_back(8'hC3);
        rbyte(1'b0, d);
        e = exp_rd_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL read_byte0: got %h want %h", d, e); end
        rbyte(1'b1, d);
        e = exp_rd_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL read_byte1: got %h want %h", d, e); end
        i2c_stop();
        n_checks += 2;
        if (mem_addr !== 8'h12) begin n_fail++; $display("FAIL read_pointer: got %h want 12", mem_addr); end
        if (obs_n !== obs_idx) begin n_fail++; $display("FAIL read_no_strobe: got %0d strobes want 0", obs_n - obs_idx); end
        obs_idx = obs_n;
    endtask

    task automatic test_write_burst();
        logic ack;
        logic [15:0] e;
        logic [7:0] data [3];
        data[0] = 8'h01; data[1] = 8'h02; data[2] = 8'h03;
        i2c_start();
        wbyte(8'hA0, ack);
        wbyte(8'hFE, ack);
        for (int i = 0; i < 3; i++) begin
            exp_wr_q.push_back({8'(8'hFE + i), data[i]});
            wbyte(data[i], ack);
            n_checks++;
            if (ack !== 1'b0) begin n_fail++; $display("FAIL burst_ack%0d: got %b want 0", i, ack); end
        end
        i2c_stop();
        while (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            n_checks++;
            if (obs_idx >= obs_n) begin
                n_fail++; $display("FAIL burst_strobe: missing, want addr/data %h", e);
            end else begin
                if (obs_wr[obs_idx] !== e) begin n_fail++; $display("FAIL burst_strobe: got %h want %h", obs_wr[obs_idx], e); end
                obs_idx++;
            end
        end
        n_checks += 2;
        if (obs_n !== obs_idx) begin n_fail++; $display("FAIL burst_strobe_count: got %0d want %0d", obs_n, obs_idx); end
        obs_idx = obs_n;
        if (mem_addr !== 8'h01) begin n_fail++; $display("FAIL burst_pointer: got %h want 01", mem_addr); end
    endtask

    task automatic test_addr_mismatch();
        logic ack;
        i2c_start();
        wbyte(8'hA2, ack);
        n_checks += 3;
        if (ack !== 1'b1)   begin n_fail++; $display("FAIL mismatch_nack: got %b want 1", ack); end
        if (busy !== 1'b1)  begin n_fail++; $display("FAIL mismatch_busy: got %b want 1", busy); end
        if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL mismatch_release: got %b want 0", sda_oe); end
        wbyte(8'h55, ack);
        i2c_start();
        wbyte(8'hA0, ack);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL mismatch_then_match_ack: got %b want 0", ack); end
        i2c_stop();
        n_checks++;
        if (obs_n !== obs_idx) begin n_fail++; $display("FAIL mismatch_no_strobe: got %0d strobes want 0", obs_n - obs_idx); end
        obs_idx = obs_n;
    endtask

    task automatic test_stop_mid_byte();
        logic ack, r;
        i2c_start();
        wbyte(8'hA0, ack);
        wbyte(8'h20, ack);
        i2c_bit(1'b1, r);
        i2c_bit(1'b0, r);
        i2c_bit(1'b1, r);
        i2c_bit(1'b0, r);
        i2c_stop();
        repeat (20) @(negedge clk);
        n_checks += 3;
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL midstop_busy: got %b want 0", busy); end
        if (mem_addr !== 8'h20) begin n_fail++; $display("FAIL midstop_pointer: got %h want 20", mem_addr); end
        if (obs_n !== obs_idx)  begin n_fail++; $display("FAIL midstop_no_strobe: got %0d strobes want 0", obs_n - obs_idx); end
        obs_idx = obs_n;
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        logic [7:0] d, e;
        preload(8'h20, 8'h00);
        preload(8'h00, 8'h5A);
        i2c_start();
        wbyte(8'hA1, ack);
        repeat (9) @(negedge clk);
        n_checks++;
        if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rdata_drive_zero: got %b want 1", sda_oe); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL async_reset_release: got %b want 0", sda_oe); end
        repeat (3) @(negedge clk);
        n_checks += 2;
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", busy); end
        if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL async_reset_pointer: got %h want 00", mem_addr); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        i2c_start();
        wbyte(8'hA1, ack);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL post_reset_ack: got %b want 0", ack); end
        exp_rd_q.push_back(8'h5A);
        rbyte(1'b1, d);
        e = exp_rd_q.pop_front();
        n_checks++;
        if (d !== e) begin n_fail++; $display("FAIL post_reset_read: got %h want %h", d, e); end
        i2c_stop();
    endtask

    initial begin
        repeat (5) @(negedge clk);
        test_reset();
        test_write();
        test_random_read();
        test_write_burst();
        test_addr_mismatch();
        test_stop_mid_byte();
        test_reset_mid_read();
        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
